crossbar_slave_arbiter: RTL and testbench
=========================================

# crossbar_slave_arbiter

Round-robin arbiter that shares one crossbar slave port between N masters. Sits in front of the per-slave interface block: picks one requesting master, drives its request/address/write-data/command toward the slave with the connection-approved qualifier asserted, and routes the slave's ack and read data back to the granted master only. Holds the grant for one complete req/ack transaction, then rotates priority.

## Interface
- N_MASTERS, 2: number of masters competing for this slave (2..8).
- AW, 32: address width.
- DW, 32: data width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_from_master  in  N_MASTERS  per-master request; held high until that master sees ack.
- addr_from_master  in  N_MASTERS*AW  flattened addresses; master i in bits [i*AW +: AW].
- wdata_from_master  in  N_MASTERS*DW  flattened write data.
- cmd_from_master  in  N_MASTERS  1 = write, 0 = read.
- ack_to_master  out  N_MASTERS  one-hot or zero; only the granted bit may be set.
- rdata_to_master  out  N_MASTERS*DW  read data; only the granted slice is nonzero.
- req_to_slave  out  1  request toward the slave interface.
- addr_to_slave  out  AW  granted master's address, zero when idle.
- wdata_to_slave  out  DW  granted master's write data, zero when idle.
- cmd_to_slave  out  1  granted master's command, zero when idle.
- connect_approved  out  1  high exactly while a grant is held.
- ack_from_slave  in  1  single-cycle completion pulse from the slave interface.
- rdata_from_slave  in  DW  read data, valid with ack_from_slave.

## Operation
- States: IDLE, BUSY. Registers: state, grant_idx (log2 N_MASTERS), rr_ptr (log2 N_MASTERS).
- IDLE: if any req_from_master bit is set, select the first set bit searching from rr_ptr upward with wrap-around; register grant_idx, go to BUSY. No requests: stay IDLE.
- BUSY: connect_approved = 1; req_to_slave = req_from_master[grant_idx]; addr/wdata/cmd muxed from grant_idx; ack_to_master[grant_idx] = ack_from_slave; rdata_to_master slice grant_idx = rdata_from_slave, all other slices zero.
- BUSY exit on ack_from_slave = 1: go IDLE, rr_ptr <= grant_idx + 1 (mod N_MASTERS).
- BUSY exit on abort (req_from_master[grant_idx] = 0 without ack): go IDLE, rr_ptr <= grant_idx + 1; ack_from_slave ignored thereafter.
- IDLE outputs: connect_approved, req_to_slave, cmd_to_slave, addr_to_slave, wdata_to_slave, ack_to_master, rdata_to_master all zero.
- Non-granted masters never receive ack or data, regardless of slave activity.

## Timing
- Reset: state = IDLE, grant_idx = 0, rr_ptr = 0; all outputs zero in the cycle after rst is sampled high. Reset mid-transaction drops the grant immediately; a late ack is not forwarded.
- Grant latency: request visible at edge t -> connect_approved and req_to_slave high from cycle t+1.
- Ack path is combinational within BUSY (zero added latency slave->master).
- Release: grant drops the cycle after the ack cycle; a new grant (any master) is earliest one further cycle later, i.e. one idle bubble between back-to-back transactions.
- Simultaneous requests: resolved solely by rr_ptr; a master requesting continuously is served at least once every N_MASTERS transactions.
- ack_from_slave in IDLE: ignored.
- N_MASTERS not a power of two: pointer increment wraps at N_MASTERS-1 -> 0 explicitly.

## Structure
- Shared crossbar package: AW/DW defaults, state encoding constants (IDLE, BUSY), cmd encoding (CMD_READ = 0, CMD_WRITE = 1).
- One sub-module: rr_priority_pick (request vector + pointer -> found flag + index), combinational, reused by the other crossbar arbiters.
- Payload muxing and ack/rdata demuxing stay in the top module.

## Test plan
- Reset: rst high 2 cycles during a live BUSY grant -> all outputs 0 next cycle, rr_ptr = 0, later ack_from_slave pulse not forwarded.
- Single read: master 1 req, cmd = 0, addr = 0x0000_0010; ack after 3 cycles with rdata 0xDEAD_BEEF -> addr_to_slave = 0x10 from t+1, ack_to_master = 2'b10 and rdata slice 1 = 0xDEAD_BEEF in ack cycle, slice 0 = 0.
- Contention: both masters req from reset -> master 0 served first, then master 1, then master 0; one idle cycle between each grant.
- Write: master 0 cmd = 1, wdata = 0x1234_5678 -> wdata_to_slave = 0x1234_5678, cmd_to_slave = 1, rdata_to_master all zero even if slave drives rdata = 0xFFFF_FFFF.
- Abort: master 1 granted, drops req before ack -> IDLE next cycle, rr_ptr = 0, subsequent ack pulse produces no ack_to_master.
- Wrap: N_MASTERS = 3, all requesting continuously for 6 transactions -> grant order 0,1,2,0,1,2.

Source files
------------

// File: rtl/crossbar_slave_arbiter_pkg.sv
// rtl/crossbar_slave_arbiter_pkg.sv - shared crossbar defaults, state and command encodings
package crossbar_slave_arbiter_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  // Command encoding carried on the cmd lines
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Arbiter state: IDLE waits for a request, BUSY holds one grant
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/crossbar_slave_arbiter_rr_priority_pick.sv
// rtl/crossbar_slave_arbiter_rr_priority_pick.sv - first set request at or after a pointer, with wrap
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int cand;

  // Scan offsets from the far end so the nearest requester to ptr wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/crossbar_slave_arbiter.sv
// rtl/crossbar_slave_arbiter.sv - round-robin arbiter sharing one crossbar slave port among masters
module crossbar_slave_arbiter
  import crossbar_slave_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS-1:0]    req_from_master,
  input  logic [N_MASTERS*AW-1:0] addr_from_master,
  input  logic [N_MASTERS*DW-1:0] wdata_from_master,
  input  logic [N_MASTERS-1:0]    cmd_from_master,
  output logic [N_MASTERS-1:0]    ack_to_master,
  output logic [N_MASTERS*DW-1:0] rdata_to_master,
  output logic                   req_to_slave,
  output logic [AW-1:0]          addr_to_slave,
  output logic [DW-1:0]          wdata_to_slave,
  output logic                   cmd_to_slave,
  output logic                   connect_approved,
  input  logic                   ack_from_slave,
  input  logic [DW-1:0]          rdata_from_slave
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;

  // Explicit wrap so non-power-of-two master counts rotate correctly
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] g);
    if (int'(g) == N_MASTERS - 1) begin
      return '0;
    end
    return g + 1'b1;
  endfunction

  rr_priority_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_pick (
    .req   (req_from_master),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State, grant and priority pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Next state: grant in IDLE, release on ack or on the granted master dropping its request
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = BUSY;
          grant_idx_d = pick_idx;
        end
      end
      BUSY: begin
        if (ack_from_slave || !req_from_master[grant_idx_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(grant_idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload mux toward the slave and ack/rdata demux back to the granted master only
  always_comb begin
    connect_approved = 1'b0;
    req_to_slave     = 1'b0;
    addr_to_slave    = '0;
    wdata_to_slave   = '0;
    cmd_to_slave     = 1'b0;
    ack_to_master    = '0;
    rdata_to_master  = '0;
    if (state_q == BUSY) begin
      connect_approved = 1'b1;
      req_to_slave     = req_from_master[grant_idx_q];
      addr_to_slave    = addr_from_master[grant_idx_q*AW +: AW];
      wdata_to_slave   = wdata_from_master[grant_idx_q*DW +: DW];
      cmd_to_slave     = cmd_from_master[grant_idx_q];
      ack_to_master[grant_idx_q] = ack_from_slave;
      // Writes return no data, so slave read-data noise never reaches the master
      if (cmd_from_master[grant_idx_q] == CMD_READ) begin
        rdata_to_master[grant_idx_q*DW +: DW] = rdata_from_slave;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// tb/tb_crossbar_slave_arbiter.sv - scoreboard bench for crossbar_slave_arbiter (2 and 3 masters)
module tb_crossbar_slave_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // two-master instance
  logic [1:0]  req2 = '0;
  logic [63:0] addr2 = '0;
  logic [63:0] wdata2 = '0;
  logic [1:0]  cmd2 = '0;
  logic [1:0]  ack_m2;
  logic [63:0] rdata_m2;
  logic        req_s2;
  logic [31:0] addr_s2;
  logic [31:0] wdata_s2;
  logic        cmd_s2;
  logic        ca2;
  logic        ack_s2 = 1'b0;
  logic [31:0] rdata_s2 = '0;

  // three-master instance
  logic [2:0]  req3 = '0;
  logic [95:0] addr3 = {32'h102, 32'h101, 32'h100};
  logic [95:0] wdata3 = '0;
  logic [2:0]  cmd3 = '0;
  logic [2:0]  ack_m3;
  logic [95:0] rdata_m3;
  logic        req_s3;
  logic [31:0] addr_s3;
  logic [31:0] wdata_s3;
  logic        cmd_s3;
  logic        ca3;
  logic        ack_s3 = 1'b0;
  logic [31:0] rdata_s3 = '0;

  crossbar_slave_arbiter #(.N_MASTERS(2), .AW(32), .DW(32)) u_dut2 (
    .clk               (clk),
    .rst               (rst),
    .req_from_master   (req2),
    .addr_from_master  (addr2),
    .wdata_from_master (wdata2),
    .cmd_from_master   (cmd2),
    .ack_to_master     (ack_m2),
    .rdata_to_master   (rdata_m2),
    .req_to_slave      (req_s2),
    .addr_to_slave     (addr_s2),
    .wdata_to_slave    (wdata_s2),
    .cmd_to_slave      (cmd_s2),
    .connect_approved  (ca2),
    .ack_from_slave    (ack_s2),
    .rdata_from_slave  (rdata_s2)
  );

  crossbar_slave_arbiter #(.N_MASTERS(3), .AW(32), .DW(32)) u_dut3 (
    .clk               (clk),
    .rst               (rst),
    .req_from_master   (req3),
    .addr_from_master  (addr3),
    .wdata_from_master (wdata3),
    .cmd_from_master   (cmd3),
    .ack_to_master     (ack_m3),
    .rdata_to_master   (rdata_m3),
    .req_to_slave      (req_s3),
    .addr_to_slave     (addr_s3),
    .wdata_to_slave    (wdata_s3),
    .cmd_to_slave      (cmd_s3),
    .connect_approved  (ca3),
    .ack_from_slave    (ack_s3),
    .rdata_from_slave  (rdata_s3)
  );

  int vectors = 0;
  int errors  = 0;

  logic [31:0] q2[$];
  logic [31:0] q3[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: each new grant must present the next expected master address
  logic ca2_prev = 1'b0;
  always @(negedge clk) begin
    if (ca2 === 1'b1 && ca2_prev !== 1'b1) begin
      if (q2.size() == 0) chk("sb2_extra_grant", 64'd1, 64'd0);
      else chk("sb2_grant_addr", 64'(addr_s2), 64'(q2.pop_front()));
    end
    ca2_prev = ca2;
  end

  logic ca3_prev = 1'b0;
  always @(negedge clk) begin
    if (ca3 === 1'b1 && ca3_prev !== 1'b1) begin
      if (q3.size() == 0) chk("sb3_extra_grant", 64'd1, 64'd0);
      else chk("sb3_grant_addr", 64'(addr_s3), 64'(q3.pop_front()));
    end
    ca3_prev = ca3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int order2 [3];
    order2 = '{0, 1, 0};

    // reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_ca", 64'(ca2), 64'd0);
    chk("rst_req_s", 64'(req_s2), 64'd0);
    chk("rst_addr_s", 64'(addr_s2), 64'd0);
    chk("rst_wdata_s", 64'(wdata_s2), 64'd0);
    chk("rst_cmd_s", 64'(cmd_s2), 64'd0);
    chk("rst_ack_m", 64'(ack_m2), 64'd0);
    chk("rst_rdata_m", rdata_m2, 64'd0);

    // single read from master 1
    tick();
    rst = 1'b0;
    req2 = 2'b10;
    addr2[63:32] = 32'h0000_0010;
    addr2[31:0]  = 32'h0000_0020;
    cmd2 = 2'b00;
    q2.push_back(32'h10);
    @(negedge clk);
    chk("rd_ca_not_yet", 64'(ca2), 64'd0);
    tick();
    @(negedge clk);
    chk("rd_ca", 64'(ca2), 64'd1);
    chk("rd_req_s", 64'(req_s2), 64'd1);
    chk("rd_addr_s", 64'(addr_s2), 64'h10);
    tick();
    tick();
    tick();
    ack_s2 = 1'b1;
    rdata_s2 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_ack_m", 64'(ack_m2), 64'h2);
    chk("rd_rdata1", 64'(rdata_m2[63:32]), 64'hDEAD_BEEF);
    chk("rd_rdata0", 64'(rdata_m2[31:0]), 64'd0);
    tick();
    ack_s2 = 1'b0;
    rdata_s2 = '0;
    req2 = 2'b00;
    @(negedge clk);
    chk("rd_release", 64'(ca2), 64'd0);

    // write from master 0, slave drives garbage rdata
    tick();
    req2 = 2'b01;
    cmd2 = 2'b01;
    wdata2[31:0] = 32'h1234_5678;
    q2.push_back(32'h20);
    tick();
    @(negedge clk);
    chk("wr_wdata_s", 64'(wdata_s2), 64'h1234_5678);
    chk("wr_cmd_s", 64'(cmd_s2), 64'd1);
    tick();
    ack_s2 = 1'b1;
    rdata_s2 = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wr_ack_m", 64'(ack_m2), 64'h1);
    chk("wr_rdata_zero", rdata_m2, 64'd0);
    tick();
    ack_s2 = 1'b0;
    rdata_s2 = '0;
    req2 = 2'b00;
    cmd2 = 2'b00;

    // abort: master 1 drops its request before any ack
    tick();
    req2 = 2'b10;
    q2.push_back(32'h10);
    tick();
    @(negedge clk);
    chk("ab_ca", 64'(ca2), 64'd1);
    tick();
    req2 = 2'b00;
    @(negedge clk);
    chk("ab_req_s_low", 64'(req_s2), 64'd0);
    tick();
    ack_s2 = 1'b1;
    rdata_s2 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ab_idle", 64'(ca2), 64'd0);
    chk("ab_no_ack", 64'(ack_m2), 64'd0);
    chk("ab_no_rdata", rdata_m2, 64'd0);
    tick();
    ack_s2 = 1'b0;
    rdata_s2 = '0;

    // move pointer to 1 (serve master 0), then reset during master 1 grant
    req2 = 2'b01;
    q2.push_back(32'h20);
    tick();
    tick();
    ack_s2 = 1'b1;
    tick();
    ack_s2 = 1'b0;
    req2 = 2'b10;
    q2.push_back(32'h10);
    tick();
    @(negedge clk);
    chk("rs_grant", 64'(ca2), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    ack_s2 = 1'b1;
    rdata_s2 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rs_ca", 64'(ca2), 64'd0);
    chk("rs_req_s", 64'(req_s2), 64'd0);
    chk("rs_addr_s", 64'(addr_s2), 64'd0);
    chk("rs_ack_m", 64'(ack_m2), 64'd0);
    chk("rs_rdata_m", rdata_m2, 64'd0);
    tick();
    rst = 1'b0;
    req2 = 2'b00;
    @(negedge clk);
    chk("rs_late_ack", 64'(ack_m2), 64'd0);
    tick();
    ack_s2 = 1'b0;
    rdata_s2 = '0;

    // contention from reset pointer: 0, 1, 0 with one idle bubble between
    tick();
    req2 = 2'b11;
    q2.push_back(32'h20);
    q2.push_back(32'h10);
    q2.push_back(32'h20);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      if (i > 0) chk("ct_regrant_after_bubble", 64'(ca2), 64'd1);
      while (ca2 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (ca2 !== 1'b1) chk("ct_grant_timeout", 64'd0, 64'd1);
      tick();
      ack_s2 = 1'b1;
      @(negedge clk);
      chk("ct_ack_m", 64'(ack_m2), 64'(2'b01 << order2[i]));
      tick();
      ack_s2 = 1'b0;
      if (i == 2) req2 = 2'b00;
      @(negedge clk);
      chk("ct_bubble", 64'(ca2), 64'd0);
    end

    // three masters requesting continuously: 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) q3.push_back(32'h100 + 32'(k % 3));
    tick();
    req3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      @(negedge clk);
      while (ca3 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (ca3 !== 1'b1) chk("wr3_grant_timeout", 64'd0, 64'd1);
      tick();
      ack_s3 = 1'b1;
      @(negedge clk);
      chk("wr3_ack_m", 64'(ack_m3), 64'(3'b001 << (k % 3)));
      tick();
      ack_s3 = 1'b0;
      if (k == 5) req3 = 3'b000;
    end

    tick();
    tick();
    chk("sb2_drained", 64'(q2.size()), 64'd0);
    chk("sb3_drained", 64'(q3.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
